chunked_adder: RTL
==================

CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per cycle; WIDTH % CHUNK == 0 required, NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have clk  input  1  rising-edge clock.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have in_valid  input  1  operation request.
REQ-006 SHALL have in_ready  output  1  block can accept a request.
REQ-007 SHALL have op_a, op_b  input  WIDTH  operands.
REQ-008 SHALL have sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1, carry_in ignored).
REQ-009 SHALL have carry_in  input  1  carry into bit 0 when sub=0.
REQ-010 SHALL have out_valid  output  1  result available.
REQ-011 SHALL have out_ready  input  1  consumer takes result.
REQ-012 SHALL have result  output  WIDTH  sum/difference.
REQ-013 SHALL have carry_out, overflow, zero, negative  output  1 each  status flags.

Function
REQ-014 SHALL implement FSM IDLE, BUSY, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-015 IDLE: on in_valid&&in_ready, latch op_a, op_b (inverted if sub), effective cin (1 if sub), clear chunk index, go BUSY.
REQ-016 BUSY: each cycle add chunk i (bits i*CHUNK..i*CHUNK+CHUNK-1) with running carry, write result chunk, increment i; after chunk NCHUNK-1 go DONE.
REQ-017 Latency: accept at edge k, out_valid high after edge k+NCHUNK; NCHUNK=1 gives one-cycle BUSY.
REQ-018 DONE: result and flags held stable until out_valid&&out_ready, then IDLE; next accept earliest one edge later.
REQ-019 in_valid and operand changes outside IDLE SHALL be ignored; operands are used only as latched.
REQ-020 carry_out = carry out of bit WIDTH-1 (for sub: 1 = no borrow); overflow = carry into MSB XOR carry out of MSB.
REQ-021 zero = (result==0); negative = result[WIDTH-1]; flags computed on final (post-saturation) result except overflow and carry_out.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, result=0, all flags 0, out_valid=0, in_ready=1 after release; in-flight operation discarded.
REQ-023 First accept SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-024 Macro CHUNKED_ADDER_SAT_EN defined: on signed overflow result SHALL clamp to 2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow); overflow still 1.
REQ-025 Macro undefined: result SHALL wrap modulo 2^WIDTH; no saturation logic present.

Structure
REQ-026 Shared package adder_pkg SHALL hold the FSM state typedef (IDLE/BUSY/DONE) and default WIDTH/CHUNK constants.
REQ-027 Sub-module chunk_add (combinational CHUNK-bit adder: a, b, cin -> sum, cout, carry into top bit) SHALL be instantiated once.

Verification (WIDTH=16, CHUNK=4)
REQ-028 0x1234 + 0x1111, sub=0, cin=0 -> result 0x2345, all flags 0, out_valid exactly 4 edges after accept.
REQ-029 0xFFFF + 0x0001 -> result 0x0000, carry_out=1, zero=1, overflow=0, negative=0.
REQ-030 0x7FFF + 0x0001 -> without SAT_EN 0x8000, overflow=1, negative=1; with SAT_EN 0x7FFF, overflow=1, negative=0.
REQ-031 sub: 0x0005 - 0x0007 -> result 0xFFFE, carry_out=0, negative=1, overflow=0.
REQ-032 out_ready low 3 cycles in DONE with in_valid high and new operands -> result stable, in_ready=0, new request not taken until after handshake.
REQ-033 rst_n low during 2nd BUSY cycle -> out_valid=0, result=0 immediately; after release 0x0001+0x0002 gives 0x0003.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and default sizing for the chunked adder.
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef struct packed {
        logic carry_out;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

endpackage

// File: rtl/chunk_add.sv
// Combinational W-bit adder slice; also reports the carry into its top bit.
module chunk_add #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ctop
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum  = full[W-1:0];
    assign cout = full[W];
    // The top sum bit is a^b^carry_in, so the carry into it falls out directly.
    assign ctop = sum[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor processing CHUNK bits per cycle with valid/ready handshakes.
// Optional saturation on signed overflow: define CHUNKED_ADDER_SAT_EN.
module chunked_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_cfg_check
        $error("chunked_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    flags_t           flags_q, flags_d;

    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             chunk_cout, chunk_ctop;
    logic [WIDTH-1:0] raw_result, final_result;
    logic             ovf;

    assign a_chunk = a_q[CHUNK*idx_q +: CHUNK];
    assign b_chunk = b_q[CHUNK*idx_q +: CHUNK];

    chunk_add #(
        .W (CHUNK)
    ) u_chunk_add (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .sum  (sum_chunk),
        .cout (chunk_cout),
        .ctop (chunk_ctop)
    );

    // Only meaningful on the last chunk, where chunk_ctop is the carry into the MSB.
    assign ovf = chunk_ctop ^ chunk_cout;

    always_comb begin
        raw_result = result_q;
        raw_result[CHUNK*idx_q +: CHUNK] = sum_chunk;
`ifdef CHUNKED_ADDER_SAT_EN
        // Wrapped MSB set means the true result was positive and too large.
        if (ovf) begin
            final_result = raw_result[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                               : {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            final_result = raw_result;
        end
`else
        final_result = raw_result;
`endif
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        flags_d  = flags_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub | carry_in;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                result_d = raw_result;
                carry_d  = chunk_cout;
                idx_d    = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    result_d          = final_result;
                    flags_d.carry_out = chunk_cout;
                    flags_d.overflow  = ovf;
                    flags_d.zero      = (final_result == '0);
                    flags_d.negative  = final_result[WIDTH-1];
                    state_d           = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = flags_q.carry_out;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;

endmodule
